// File: rtl/atm_teclado_if.sv
// Keypad front-end bus: raw keypad inputs and mode select toward the DUT,
// the PIN digit and the committed amount back toward the ATM controller.
interface atm_teclado_if;
   logic        TECLA_ACTIVA;
   logic [3:0]  TECLA;
   logic        MODO_MONTO;
   logic [3:0]  DIGITO;
   logic        DIGITO_STB;
   logic [31:0] MONTO;
   logic        MONTO_STB;
   logic        MONTO_DESBORDE;

   modport master (
      output TECLA_ACTIVA, TECLA, MODO_MONTO,
      input  DIGITO, DIGITO_STB, MONTO, MONTO_STB, MONTO_DESBORDE
   );

   modport slave (
      input  TECLA_ACTIVA, TECLA, MODO_MONTO,
      output DIGITO, DIGITO_STB, MONTO, MONTO_STB, MONTO_DESBORDE
   );
endinterface

// File: rtl/atm_teclado.sv
// Keypad front-end: debounces raw presses and turns each accepted key into
// a PIN digit strobe or an accumulated decimal amount committed on ENTER.
module atm_teclado #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned MAX_DIGITS      = 9
) (
   input  logic         CLK,
   input  logic         RESET,
   atm_teclado_if.slave kp
);
   localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned DIG_W     = $clog2(MAX_DIGITS + 1);
   localparam logic [3:0]  KEY_ENTER = 4'hA;
   localparam logic [3:0]  KEY_CLEAR = 4'hB;

   typedef enum logic [1:0] {INACTIVA, REBOTE, SOSTENIDA, LIBERACION} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
   logic [3:0]       code_q, code_d;
   logic             cnt_done_c, same_key_c, event_c;

   logic [3:0]       digito_q, digito_d;
   logic             digito_stb_q, digito_stb_d;
   logic [31:0]      monto_q, monto_d;
   logic             monto_stb_q, monto_stb_d;
   logic             desborde_q, desborde_d;
   logic [31:0]      acc_q, acc_d;
   logic [DIG_W-1:0] ndig_q, ndig_d;
   logic             modo_q, modo_d;
   logic             mode_chg_c, is_digit_c;

   assign cnt_inc_c  = cnt_q + CNT_W'(1);
   assign cnt_done_c = (cnt_inc_c == CNT_W'(DEBOUNCE_CYCLES));
   assign same_key_c = kp.TECLA_ACTIVA && (kp.TECLA == code_q);
   assign mode_chg_c = (kp.MODO_MONTO != modo_q);
   assign is_digit_c = (code_q < 4'd10);

   // Key FSM state register
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= INACTIVA;
         cnt_q   <= '0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
      end
   end

   // Key FSM next state: press debounce, hold without repeat, release debounce
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      unique case (state_q)
         INACTIVA: begin
            if (kp.TECLA_ACTIVA) begin
               code_d  = kp.TECLA;
               cnt_d   = CNT_W'(1);
               state_d = REBOTE;
            end
         end
         REBOTE: begin
            if (!same_key_c) begin
               cnt_d   = '0;
               state_d = INACTIVA;
            end else begin
               cnt_d = cnt_inc_c;
               if (cnt_done_c) state_d = SOSTENIDA;
            end
         end
         SOSTENIDA: begin
            if (!kp.TECLA_ACTIVA) begin
               cnt_d   = CNT_W'(1);
               state_d = LIBERACION;
            end
         end
         LIBERACION: begin
            if (kp.TECLA_ACTIVA) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_inc_c;
               if (cnt_done_c) state_d = INACTIVA;
            end
         end
      endcase
   end

   // Key FSM output: one event on the edge the press is accepted
   always_comb begin
      event_c = 1'b0;
      if ((state_q == REBOTE) && same_key_c && cnt_done_c) event_c = 1'b1;
   end

   // Event handling; a mode change coinciding with an event is deferred one edge
   always_comb begin
      digito_d     = digito_q;
      digito_stb_d = 1'b0;
      monto_d      = monto_q;
      monto_stb_d  = 1'b0;
      desborde_d   = desborde_q;
      acc_d        = acc_q;
      ndig_d       = ndig_q;
      modo_d       = kp.MODO_MONTO;
      if (event_c) begin
         if (mode_chg_c) modo_d = modo_q;
         if (!kp.MODO_MONTO) begin
            if (is_digit_c) begin
               digito_d     = code_q;
               digito_stb_d = 1'b1;
            end
         end else if (is_digit_c) begin
            if (ndig_q < DIG_W'(MAX_DIGITS)) begin
               acc_d  = acc_q * 32'd10 + 32'(code_q);
               ndig_d = ndig_q + DIG_W'(1);
            end else begin
               desborde_d = 1'b1;
            end
         end else if (code_q == KEY_ENTER) begin
            if (ndig_q != '0) begin
               monto_d     = acc_q;
               monto_stb_d = 1'b1;
               acc_d       = '0;
               ndig_d      = '0;
               desborde_d  = 1'b0;
            end
         end else if (code_q == KEY_CLEAR) begin
            acc_d      = '0;
            ndig_d     = '0;
            desborde_d = 1'b0;
         end
      end else if (mode_chg_c) begin
         acc_d      = '0;
         ndig_d     = '0;
         desborde_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         digito_q     <= '0;
         digito_stb_q <= 1'b0;
         monto_q      <= '0;
         monto_stb_q  <= 1'b0;
         desborde_q   <= 1'b0;
         acc_q        <= '0;
         ndig_q       <= '0;
         modo_q       <= 1'b0;
      end else begin
         digito_q     <= digito_d;
         digito_stb_q <= digito_stb_d;
         monto_q      <= monto_d;
         monto_stb_q  <= monto_stb_d;
         desborde_q   <= desborde_d;
         acc_q        <= acc_d;
         ndig_q       <= ndig_d;
         modo_q       <= modo_d;
      end
   end

   assign kp.DIGITO         = digito_q;
   assign kp.DIGITO_STB     = digito_stb_q;
   assign kp.MONTO          = monto_q;
   assign kp.MONTO_STB      = monto_stb_q;
   assign kp.MONTO_DESBORDE = desborde_q;

endmodule

// File: tb/tb_atm_teclado.sv
// Bench for atm_teclado: directed scenarios with literal expectations plus
// randomized keypad activity checked every cycle against a behavioural model.
module tb_atm_teclado;
   localparam int unsigned DEB  = 4;
   localparam int unsigned MAXD = 9;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   atm_teclado_if bus ();

   atm_teclado #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(MAXD)) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .kp   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int dstb_cnt = 0;
   int mstb_cnt = 0;
   logic [3:0]  last_dig   = '0;
   logic [31:0] last_monto = '0;

   // Behavioural model: key phase 0 idle, 1 pressing, 2 held, 3 releasing
   int          phase = 0;
   int          run   = 0;
   logic [3:0]  pc    = '0;
   logic [3:0]  m_dig = '0;
   logic        m_dstb = 1'b0, m_mstb = 1'b0, m_desb = 1'b0;
   logic [31:0] m_monto = '0;
   logic [31:0] acc = '0;
   int          ndig = 0;
   logic        last_mode = 1'b0;

   bit pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic clear_amount();
      acc    = '0;
      ndig   = 0;
      m_desb = 1'b0;
   endtask

   task automatic model_step();
      bit   ev;
      logic a, md;
      logic [3:0] c;
      a  = bus.TECLA_ACTIVA;
      c  = bus.TECLA;
      md = bus.MODO_MONTO;
      m_dstb = 1'b0;
      m_mstb = 1'b0;
      if (!RESET) begin
         phase = 0; run = 0; pc = '0; m_dig = '0; m_monto = '0;
         clear_amount();
         last_mode = 1'b0;
         return;
      end
      ev = 1'b0;
      case (phase)
         0: if (a) begin pc = c; run = 1; phase = 1; end
         1: if (!a || c != pc) phase = 0;
            else begin run++; if (run == DEB) begin ev = 1'b1; phase = 2; end end
         2: if (!a) begin run = 1; phase = 3; end
         default: if (a) run = 0;
            else begin run++; if (run == DEB) phase = 0; end
      endcase
      if (ev) begin
         if (!md) begin
            if (pc < 10) begin m_dig = pc; m_dstb = 1'b1; end
         end else if (pc < 10) begin
            if (ndig < MAXD) begin acc = acc * 10 + 32'(pc); ndig++; end
            else m_desb = 1'b1;
         end else if (pc == 4'hA) begin
            if (ndig > 0) begin m_monto = acc; m_mstb = 1'b1; clear_amount(); end
         end else if (pc == 4'hB) begin
            clear_amount();
         end
      end else begin
         if (md != last_mode) clear_amount();
         last_mode = md;
      end
   endtask

   // One clock: advance the model, then compare every output
   task automatic step();
      @(posedge CLK);
      model_step();
      #1;
      chk("digito",     32'(bus.DIGITO),         32'(m_dig));
      chk("digito_stb", 32'(bus.DIGITO_STB),     32'(m_dstb));
      chk("monto",      bus.MONTO,               m_monto);
      chk("monto_stb",  32'(bus.MONTO_STB),      32'(m_mstb));
      chk("desborde",   32'(bus.MONTO_DESBORDE), 32'(m_desb));
      chk("stb_excl",   32'(bus.DIGITO_STB & bus.MONTO_STB), 32'd0);
      if (bus.DIGITO_STB === 1'b1) begin dstb_cnt++; last_dig = bus.DIGITO; end
      if (bus.MONTO_STB === 1'b1) begin mstb_cnt++; last_monto = bus.MONTO; end
   endtask

   task automatic press(input logic [3:0] k, input int hi, input int lo, output int lat);
      int bd, bm;
      bd  = dstb_cnt;
      bm  = mstb_cnt;
      lat = -1;
      bus.TECLA        = k;
      bus.TECLA_ACTIVA = 1'b1;
      for (int i = 1; i <= hi; i++) begin
         step();
         if (lat < 0 && (dstb_cnt != bd || mstb_cnt != bm)) lat = i;
      end
      bus.TECLA_ACTIVA = 1'b0;
      repeat (lo) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, n, bd, bm;
      logic [3:0] keys [4];

      RESET = 1'b0;
      bus.TECLA_ACTIVA = 1'b1;
      bus.TECLA        = 4'd5;
      bus.MODO_MONTO   = 1'b0;
      step();
      step();
      chk("rst_digito",     32'(bus.DIGITO),         32'd0);
      chk("rst_digito_stb", 32'(bus.DIGITO_STB),     32'd0);
      chk("rst_monto",      bus.MONTO,               32'd0);
      chk("rst_monto_stb",  32'(bus.MONTO_STB),      32'd0);
      chk("rst_desborde",   32'(bus.MONTO_DESBORDE), 32'd0);

      // Release reset with the key held: strobe on the fourth edge
      RESET = 1'b1;
      n = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (bus.DIGITO_STB === 1'b1) begin n = i; break; end
      end
      chk("rst_release_lat", 32'(n), 32'd4);
      chk("rst_release_dig", 32'(last_dig), 32'd5);
      bus.TECLA_ACTIVA = 1'b0;
      repeat (6) step();

      // PIN entry, clean presses
      keys = '{4'd1, 4'd2, 4'd3, 4'd4};
      bd = dstb_cnt;
      for (int i = 0; i < 4; i++) begin
         press(keys[i], 6, 6, lat);
         chk("pin_lat", 32'(lat), 32'd4);
         chk("pin_dig", 32'(last_dig), 32'(i + 1));
      end
      chk("pin_count", 32'(dstb_cnt - bd), 32'd4);

      // Bounce rejection, then a too-short press
      bd = dstb_cnt;
      bus.TECLA = 4'd7;
      for (int i = 0; i < 9; i++) begin
         bus.TECLA_ACTIVA = pat[i];
         step();
      end
      bus.TECLA_ACTIVA = 1'b0;
      repeat (6) step();
      chk("bounce_count", 32'(dstb_cnt - bd), 32'd1);
      chk("bounce_dig",   32'(last_dig), 32'd7);
      bd = dstb_cnt;
      press(4'd8, 3, 6, lat);
      chk("short_press", 32'(dstb_cnt - bd), 32'd0);

      // Amount commit and clear
      bus.MODO_MONTO = 1'b1;
      repeat (2) step();
      bd = dstb_cnt;
      bm = mstb_cnt;
      press(4'd2, 6, 6, lat);
      press(4'd5, 6, 6, lat);
      press(4'd0, 6, 6, lat);
      press(4'hA, 6, 6, lat);
      chk("amt_commit_cnt", 32'(mstb_cnt - bm), 32'd1);
      chk("amt_commit_val", last_monto, 32'd250);
      chk("amt_no_digito",  32'(dstb_cnt - bd), 32'd0);
      bm = mstb_cnt;
      press(4'd9, 6, 6, lat);
      press(4'hB, 6, 6, lat);
      press(4'hA, 6, 6, lat);
      chk("amt_clear_nostb", 32'(mstb_cnt - bm), 32'd0);
      chk("amt_clear_hold",  bus.MONTO, 32'd250);

      // Max-digit overflow
      for (int i = 0; i < 10; i++) begin
         press(4'd9, 6, 6, lat);
         if (i == 8) chk("ovf_before", 32'(bus.MONTO_DESBORDE), 32'd0);
      end
      chk("ovf_flag", 32'(bus.MONTO_DESBORDE), 32'd1);
      bm = mstb_cnt;
      press(4'hA, 6, 6, lat);
      chk("ovf_commit_cnt", 32'(mstb_cnt - bm), 32'd1);
      chk("ovf_commit_val", last_monto, 32'd999999999);
      chk("ovf_flag_clr",   32'(bus.MONTO_DESBORDE), 32'd0);

      // Mode toggle discards a partial amount
      press(4'd4, 6, 6, lat);
      press(4'd2, 6, 6, lat);
      bus.MODO_MONTO = 1'b0;
      repeat (2) step();
      bus.MODO_MONTO = 1'b1;
      repeat (2) step();
      bm = mstb_cnt;
      press(4'hA, 6, 6, lat);
      chk("mode_abort_nostb", 32'(mstb_cnt - bm), 32'd0);
      chk("mode_abort_hold",  bus.MONTO, 32'd999999999);

      // Reset pulse during debounce: no strobe, key FSM back to idle
      bus.MODO_MONTO = 1'b0;
      repeat (2) step();
      bd = dstb_cnt;
      bus.TECLA = 4'd3;
      bus.TECLA_ACTIVA = 1'b1;
      repeat (2) step();
      RESET = 1'b0;
      bus.TECLA_ACTIVA = 1'b0;
      step();
      RESET = 1'b1;
      repeat (8) step();
      chk("rst_rebote_nostb", 32'(dstb_cnt - bd), 32'd0);
      press(4'd3, 6, 6, lat);
      chk("rst_rebote_after", 32'(lat), 32'd4);

      // Randomized keypad activity with bounces, mode flips and rare resets
      for (int seg = 0; seg < 150; seg++) begin
         int r, hi, lo;
         logic [3:0] k;
         r = int'($urandom_range(0, 99));
         if (r < 4) begin
            RESET = 1'b0;
            step();
            RESET = 1'b1;
         end
         if (r >= 4 && r < 18) bus.MODO_MONTO = ~bus.MODO_MONTO;
         if ($urandom_range(0, 3) == 0) k = 4'($urandom_range(10, 15));
         else                           k = 4'($urandom_range(0, 9));
         bus.TECLA = k;
         hi = int'($urandom_range(1, 9));
         for (int i = 0; i < hi; i++) begin
            bus.TECLA_ACTIVA = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 11) == 0) bus.TECLA = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) bus.MODO_MONTO = ~bus.MODO_MONTO;
            step();
         end
         lo = int'($urandom_range(1, 10));
         for (int i = 0; i < lo; i++) begin
            bus.TECLA_ACTIVA = ($urandom_range(0, 9) == 0);
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/atm_teclado.md
# atm_teclado

Keypad front-end for the ATM controller. It debounces a raw keypad (key-active flag plus 4-bit key code) and turns each accepted press into an event. In PIN mode it forwards digits to the `atm` FSM as single-cycle `DIGITO`/`DIGITO_STB` pulses. In amount mode it assembles decimal digits into a 32-bit `MONTO` and presents it with a single-cycle `MONTO_STB` when ENTER is pressed.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples (≥2) required to accept a press or a release.
- `MAX_DIGITS`, default 9: maximum digits accumulated in amount mode. 9 guarantees ≤ 999,999,999, which fits in 32 bits.

Ports:
- `CLK` input 1: clock.
- `RESET` input 1: reset, synchronous, active-low. Clock is `CLK`.
- `TECLA_ACTIVA` input 1: raw key-pressed flag, possibly bouncing.
- `TECLA` input 4: raw key code. 0–9 are digits, 4'hA is ENTER, 4'hB is CLEAR, 4'hC–4'hF are unused.
- `MODO_MONTO` input 1: 0 selects PIN mode, 1 selects amount mode.
- `DIGITO` output 4: last accepted digit (PIN mode).
- `DIGITO_STB` output 1: one-cycle pulse per accepted PIN-mode digit.
- `MONTO` output 32: last committed amount.
- `MONTO_STB` output 1: one-cycle pulse on amount commit.
- `MONTO_DESBORDE` output 1: sticky flag, set when a digit is discarded because `MAX_DIGITS` has been reached.

## Operation
- **Reset** (`RESET`=0 at a rising edge): all outputs 0, key FSM to INACTIVA, accumulator 0, digit count 0. An in-progress debounce is abandoned with no strobe.
- **Key FSM states:**
  - INACTIVA: when `TECLA_ACTIVA`=1 is sampled, latch `TECLA`, set cnt=1, go to REBOTE.
  - REBOTE: if `TECLA_ACTIVA`=0 or `TECLA` differs from the latched code, return to INACTIVA with no event. Otherwise increment cnt. When cnt reaches `DEBOUNCE_CYCLES`, raise the event and go to SOSTENIDA.
  - SOSTENIDA: the key is held and no further events occur (no auto-repeat). When `TECLA_ACTIVA`=0 is sampled, set cnt=1 and go to LIBERACION.
  - LIBERACION: if `TECLA_ACTIVA`=1, reset cnt to 0 and stay. Otherwise increment cnt. When cnt reaches `DEBOUNCE_CYCLES`, go to INACTIVA.
- **Event handling.** `MODO_MONTO` is sampled on the edge the event is raised.
  - PIN mode, digit: `DIGITO`←code, `DIGITO_STB`=1 for one cycle.
  - PIN mode, ENTER/CLEAR/C–F: ignored, no strobe.
  - Amount mode, digit, count < `MAX_DIGITS`: acc←acc·10+code (32-bit), count+1. Leading zeros count as digits.
  - Amount mode, digit, count = `MAX_DIGITS`: digit discarded, `MONTO_DESBORDE`←1.
  - Amount mode, ENTER, count>0: `MONTO`←acc, `MONTO_STB`=1 for one cycle; acc, count and `MONTO_DESBORDE` cleared.
  - Amount mode, ENTER, count=0: ignored.
  - Amount mode, CLEAR: acc, count and `MONTO_DESBORDE` cleared, no strobe.
  - Amount mode, C–F: ignored.
- **Mode change.** Any change of `MODO_MONTO`, detected against a registered copy, clears acc, count and `MONTO_DESBORDE` on the following edge. `MONTO` and `DIGITO` are unaffected.
- **Hold behaviour.** `DIGITO` and `MONTO` hold their values between strobes. The strobes are never high for more than one cycle, because the downstream FSM counts a digit on every cycle `DIGITO_STB` is high. `DIGITO_STB` and `MONTO_STB` are never high together.

## Timing
- **Acceptance.** A press is accepted when it is sampled active with an identical code on `DEBOUNCE_CYCLES` consecutive rising edges. The strobe is high during the cycle immediately after the last of those edges. With the default of 4: first sample at edge 0, strobe high between edge 3 and edge 4.
- **Release.** Requires `DEBOUNCE_CYCLES` consecutive inactive samples. Minimum spacing between two strobes is therefore 2·`DEBOUNCE_CYCLES` cycles.
- **Glitches.** A glitch shorter than `DEBOUNCE_CYCLES` samples produces no event.
- **Code change mid-debounce.** The attempt is aborted. The new code must be re-pressed from INACTIVA.
- **Registered outputs.** All outputs are registered with no combinational path from inputs.
- **Reset timing.** Reset on the same edge an event would be raised wins: no strobe.
- **Mode change vs. event.** A mode change on the same edge as an amount event: the event is processed in the newly sampled mode, and the clear applies one edge later only if the mode differs from the registered copy at that time. The clear must never drop a just-committed `MONTO`.

## Test plan
- **Reset.** Hold `RESET`=0 for 2 cycles with `TECLA_ACTIVA`=1 → all outputs 0. Release with the key held → strobe exactly 4 edges later.
- **PIN entry, clean presses.** `MODO_MONTO`=0, clean presses of 1,2,3,4 (6 cycles high, 6 low each) → four single-cycle `DIGITO_STB` pulses with `DIGITO`=1,2,3,4, each 4 edges after its first active sample.
- **Bounce rejection.** `TECLA_ACTIVA` pattern 1,0,1,1,0,1,1,1,1 with code 7 → exactly one `DIGITO_STB` with `DIGITO`=7, after the final 4 stable samples. A 3-cycle press produces no strobe.
- **Amount commit and clear.** `MODO_MONTO`=1, keys 2,5,0,ENTER → `MONTO`=250, `MONTO_STB` one cycle, `DIGITO_STB` never high. Then 9,CLEAR,ENTER → no strobe, `MONTO` stays 250.
- **Max-digit overflow.** Amount mode, ten presses of 9 then ENTER → `MONTO_DESBORDE`=1 after the tenth press, then `MONTO`=999999999, `MONTO_STB` pulse, flag cleared.
- **Mode switch and abort.** Amount mode, keys 4,2, then `MODO_MONTO`→0→1, then ENTER → no `MONTO_STB`. Separately, `RESET`=0 pulsed during REBOTE → no strobe, FSM returns to INACTIVA.
